// File: rtl/cp0_pkg.sv
// cp0_pkg
//   Shared definitions for the coprocessor-0 interrupt controller.
//   - CP0 register numbers as seen in the rd field of mfc0/mtc0.
//   - SR/Cause bit-field positions.
//   - Interrupt handler vector, shared with the next-PC unit.
//   - Small helpers for word alignment and register-number decode.
package cp0_pkg;

  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  // SR fields
  localparam int IM_LO   = 10;
  localparam int IM_HI   = 15;
  localparam int EXL_BIT = 1;
  localparam int IE_BIT  = 0;

  // Cause fields (IP sits in the same bit positions as IM)
  localparam int IP_LO   = 10;
  localparam int IP_HI   = 15;
  localparam int EXC_LO  = 2;
  localparam int EXC_HI  = 6;

  // Widest interrupt field that fits between IM_LO and IM_HI
  localparam int MAX_INT_W = IM_HI - IM_LO + 1;

  localparam logic [31:0] INT_VEC = 32'h0000_4180;

  // PCs and EPC are always word aligned
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  // One-hot decode of the CP0 registers this controller implements
  typedef struct packed {
    logic sr;
    logic cause;
    logic epc;
    logic prid;
  } cp0_sel_t;

  function automatic cp0_sel_t cp0_decode(input logic [4:0] addr);
    cp0_sel_t s;
    s.sr    = (addr == CP0_SR);
    s.cause = (addr == CP0_CAUSE);
    s.epc   = (addr == CP0_EPC);
    s.prid  = (addr == CP0_PRID);
    return s;
  endfunction

endpackage

// File: rtl/cp0_sync.sv
// cp0_sync
//   Parameterised-width two-flop synchroniser with synchronous active-low
//   reset. Each bit is synchronised independently; lines are level
//   signals, so no multi-bit coherency is needed.
// Ports
//   i_clk   core clock
//   i_rst   synchronous reset, active low, clears both stages
//   i_d     asynchronous input lines
//   o_q     synchronised lines (two clocks of latency)
module cp0_sync #(
  parameter int W = 6
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/cp0_int_ctrl.sv
// cp0_int_ctrl
//   Coprocessor-0 exception/interrupt controller for the single-cycle MIPS
//   core. Owns SR, Cause, EPC and PRId, synchronises the hardware interrupt
//   lines and raises a one-cycle interrupt request that the next-PC unit
//   turns into a jump to INT_VEC.
// Ports
//   i_clk       core clock, all state on rising edge
//   i_rst       synchronous reset, active low
//   i_hw_int    asynchronous level-sensitive interrupt lines
//   i_ret_pc    address execution would resume at this cycle
//   i_cp0_addr  mfc0/mtc0 register number
//   i_cp0_we    mtc0 write strobe
//   i_cp0_din   mtc0 write data
//   i_eret      ERET executing this cycle
//   o_cp0_dout  mfc0 read data, combinational on i_cp0_addr
//   o_epc_out   current EPC, ERET target for the next-PC unit
//   o_int_req   interrupt accepted this cycle
module cp0_int_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID_VAL = 32'h4A55_0001,
  parameter int          HW_INT_W = 6
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [HW_INT_W-1:0] i_hw_int,
  input  logic [31:0]         i_ret_pc,
  input  logic [4:0]          i_cp0_addr,
  input  logic                i_cp0_we,
  input  logic [31:0]         i_cp0_din,
  input  logic                i_eret,
  output logic [31:0]         o_cp0_dout,
  output logic [31:0]         o_epc_out,
  output logic                o_int_req
);

  // IM/IP occupy bits [IM_LO +: HW_INT_W]; HW_INT_W must not exceed MAX_INT_W.

  logic [HW_INT_W-1:0] w_ip;
  logic [HW_INT_W-1:0] r_im;
  logic                r_exl;
  logic                r_ie;
  logic [31:0]         r_epc;

  logic                w_pending;
  logic                w_int_req;
  cp0_sel_t            w_sel;
  logic                w_sr_wr;
  logic                w_epc_wr;
  logic [31:0]         w_din_aligned;
  logic [31:0]         w_ret_aligned;
  logic [31:0]         w_sr_word;
  logic [31:0]         w_cause_word;

  cp0_sync #(
    .W (HW_INT_W)
  ) u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_hw_int),
    .o_q   (w_ip)
  );

  // Request logic. Everything here comes from registered state apart from
  // i_eret, which only ever masks the request off.
  assign w_pending = |(w_ip & r_im);
  assign w_int_req = w_pending & r_ie & ~r_exl & ~i_eret;

  // An accepted interrupt owns the cycle: any mtc0 issued alongside it
  // belongs to an instruction that is being abandoned, so it is dropped.
  assign w_sel    = cp0_decode(i_cp0_addr);
  assign w_sr_wr  = i_cp0_we & ~w_int_req & w_sel.sr;
  assign w_epc_wr = i_cp0_we & ~w_int_req & w_sel.epc;

  assign w_din_aligned = word_align(i_cp0_din);
  assign w_ret_aligned = word_align(i_ret_pc);

  // SR: IM, EXL, IE. The eret clear is applied after the mtc0 so that an
  // ERET coinciding with an SR write always leaves EXL cleared.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_im  <= '0;
      r_exl <= 1'b0;
      r_ie  <= 1'b0;
    end else if (w_int_req) begin
      r_exl <= 1'b1;
    end else begin
      if (w_sr_wr) begin
        r_im  <= i_cp0_din[IM_LO +: HW_INT_W];
        r_exl <= i_cp0_din[EXL_BIT];
        r_ie  <= i_cp0_din[IE_BIT];
      end
      if (i_eret) begin
        r_exl <= 1'b0;
      end
    end
  end

  // EPC: captured on acceptance, otherwise software-writable. ERET leaves
  // it alone.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_epc <= '0;
    end else if (w_int_req) begin
      r_epc <= w_ret_aligned;
    end else if (w_epc_wr) begin
      r_epc <= w_din_aligned;
    end
  end

  // Architectural views of SR and Cause; undefined bits read as zero and
  // ExcCode is hard-wired to zero (interrupts are the only cause).
  always_comb begin
    w_sr_word                    = '0;
    w_sr_word[IM_LO +: HW_INT_W] = r_im;
    w_sr_word[EXL_BIT]           = r_exl;
    w_sr_word[IE_BIT]            = r_ie;
  end

  always_comb begin
    w_cause_word                    = '0;
    w_cause_word[IP_LO +: HW_INT_W] = w_ip;
    w_cause_word[EXC_HI:EXC_LO]     = 5'd0;
  end

  // Read mux: pre-edge values, so a same-cycle write is never visible.
  always_comb begin
    o_cp0_dout = '0;
    unique case (1'b1)
      w_sel.sr:    o_cp0_dout = w_sr_word;
      w_sel.cause: o_cp0_dout = w_cause_word;
      w_sel.epc:   o_cp0_dout = r_epc;
      w_sel.prid:  o_cp0_dout = PRID_VAL;
      default:     o_cp0_dout = '0;
    endcase
  end

  assign o_epc_out = r_epc;
  assign o_int_req = w_int_req;

endmodule

// File: tb/tb_cp0_int_ctrl.sv
module tb_cp0_int_ctrl;

  localparam logic [31:0] PRID = 32'h4A55_0001;
  localparam logic [31:0] SR_VISIBLE = 32'h0000_FC03;

  logic        clk;
  logic        rst;
  logic [5:0]  hw_int;
  logic [31:0] ret_pc;
  logic [4:0]  addr;
  logic        we;
  logic [31:0] din;
  logic        eret;
  logic [31:0] dout;
  logic [31:0] epc_out;
  logic        int_req;

  int checks;
  int errs;

  cp0_int_ctrl #(
    .PRID_VAL (PRID),
    .HW_INT_W (6)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_hw_int   (hw_int),
    .i_ret_pc   (ret_pc),
    .i_cp0_addr (addr),
    .i_cp0_we   (we),
    .i_cp0_din  (din),
    .i_eret     (eret),
    .o_cp0_dout (dout),
    .o_epc_out  (epc_out),
    .o_int_req  (int_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: SR as a full 32-bit word, EPC as a word, and the last
  // two sampled hw_int values (m_hist[1] is what software sees in Cause.IP).
  logic [31:0] m_sr;
  logic [31:0] m_epc;
  logic [5:0]  m_hist [2];

  function automatic logic m_req();
    logic [5:0] im;
    im = m_sr[15:10];
    return ((m_hist[1] & im) != 6'd0) && m_sr[0] && !m_sr[1] && !eret;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr & SR_VISIBLE;
      5'd13:   return {16'd0, m_hist[1], 10'd0};
      5'd14:   return m_epc;
      5'd15:   return PRID;
      default: return 32'd0;
    endcase
  endfunction

  // Advance one clock, updating the model from the inputs applied this cycle.
  // Always returns at the falling edge with inputs still driven.
  task automatic tick();
    logic [31:0] n_sr, n_epc;
    logic [5:0]  n_h0, n_h1;
    n_sr  = m_sr;
    n_epc = m_epc;
    n_h0  = hw_int;
    n_h1  = m_hist[0];
    if (!rst) begin
      n_sr = 0; n_epc = 0; n_h0 = 0; n_h1 = 0;
    end else if (m_req()) begin
      n_epc = ret_pc & ~32'd3;
      n_sr  = m_sr | 32'd2;
    end else begin
      if (we && addr == 5'd12) n_sr  = din & SR_VISIBLE;
      if (we && addr == 5'd14) n_epc = din & ~32'd3;
      if (eret)                n_sr  = n_sr & ~32'd2;
    end
    @(posedge clk);
    m_sr = n_sr; m_epc = n_epc; m_hist[0] = n_h0; m_hist[1] = n_h1;
    @(negedge clk);
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    addr = a; din = d; we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    rst = 1'b0; hw_int = 6'h3F;
    tick(); tick();
    #1;
    checks++;
    if (int_req !== 1'b0) begin errs++; $display("FAIL reset_int_req: got %0b want 0", int_req); end
    checks++;
    if (epc_out !== 32'd0) begin errs++; $display("FAIL reset_epc_out: got %h want 0", epc_out); end
    for (int a = 12; a <= 15; a++) begin
      addr = 5'(a); #1;
      rd = (a == 15) ? PRID : 32'd0;
      checks++;
      if (dout !== rd) begin errs++; $display("FAIL reset_read_%0d: got %h want %h", a, dout, rd); end
    end
  endtask

  task automatic test_irq_entry();
    rst = 1'b1; hw_int = 6'h00;
    mtc0(5'd12, 32'h0000_0401);
    hw_int = 6'h01; ret_pc = 32'h0000_3010; addr = 5'd12;
    tick(); #1;
    checks++;
    if (int_req !== 1'b0) begin errs++; $display("FAIL entry_early: got %0b want 0 one clk after hw_int", int_req); end
    tick(); #1;
    checks++;
    if (int_req !== 1'b1) begin errs++; $display("FAIL entry_raise: got %0b want 1 two clks after hw_int", int_req); end
    tick(); #1;
    checks++;
    if (epc_out !== 32'h0000_3010) begin errs++; $display("FAIL entry_epc: got %h want 00003010", epc_out); end
    checks++;
    if (dout !== 32'h0000_0403) begin errs++; $display("FAIL entry_sr: got %h want 00000403", dout); end
    checks++;
    if (int_req !== 1'b0) begin errs++; $display("FAIL entry_one_cycle: got %0b want 0", int_req); end
  endtask

  task automatic test_eret();
    // EXL=1 and hw_int[0] still high from the entry test
    eret = 1'b1; #1;
    checks++;
    if (int_req !== 1'b0) begin errs++; $display("FAIL eret_suppress: got %0b want 0", int_req); end
    tick(); eret = 1'b0; addr = 5'd12; #1;
    checks++;
    if (dout !== 32'h0000_0401) begin errs++; $display("FAIL eret_exl_clear: got %h want 00000401", dout); end
    checks++;
    if (int_req !== 1'b1) begin errs++; $display("FAIL eret_reraise: got %0b want 1", int_req); end
    tick();
    hw_int = 6'h00;
    tick(); tick();
    eret = 1'b1; #1;
    checks++;
    if (int_req !== 1'b0) begin errs++; $display("FAIL eret_quiet_eret: got %0b want 0", int_req); end
    tick(); eret = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (int_req !== 1'b0) begin errs++; $display("FAIL eret_quiet_%0d: got %0b want 0", i, int_req); end
      tick();
    end
  endtask

  task automatic test_masking();
    mtc0(5'd12, 32'h0000_0801);
    hw_int = 6'h01; addr = 5'd13;
    tick(); tick(); tick(); #1;
    checks++;
    if (int_req !== 1'b0) begin errs++; $display("FAIL mask_blocked: got %0b want 0", int_req); end
    checks++;
    if (dout !== 32'h0000_0400) begin errs++; $display("FAIL mask_cause: got %h want 00000400", dout); end
    hw_int = 6'h03;
    tick(); #1;
    checks++;
    if (int_req !== 1'b0) begin errs++; $display("FAIL mask_line1_early: got %0b want 0", int_req); end
    tick(); #1;
    checks++;
    if (int_req !== 1'b1) begin errs++; $display("FAIL mask_line1_raise: got %0b want 1", int_req); end
    checks++;
    if (dout !== 32'h0000_0C00) begin errs++; $display("FAIL mask_cause2: got %h want 00000c00", dout); end
    tick();
    hw_int = 6'h00;
    tick(); tick();
    eret = 1'b1; tick(); eret = 1'b0;
  endtask

  task automatic test_collision();
    mtc0(5'd12, 32'h0000_0401);
    hw_int = 6'h01; ret_pc = 32'h0000_3020;
    tick(); tick();
    addr = 5'd14; din = 32'h5555_5557; we = 1'b1; #1;
    checks++;
    if (int_req !== 1'b1) begin errs++; $display("FAIL coll_req: got %0b want 1", int_req); end
    checks++;
    if (dout !== m_read(5'd14)) begin errs++; $display("FAIL coll_old_read: got %h want %h", dout, m_read(5'd14)); end
    tick(); we = 1'b0; #1;
    checks++;
    if (epc_out !== 32'h0000_3020) begin errs++; $display("FAIL coll_epc: got %h want 00003020", epc_out); end
    we = 1'b1; #1;
    checks++;
    if (dout !== 32'h0000_3020) begin errs++; $display("FAIL coll_rw_same_cycle: got %h want 00003020", dout); end
    tick(); we = 1'b0; #1;
    checks++;
    if (dout !== 32'h5555_5554) begin errs++; $display("FAIL coll_later_write: got %h want 55555554", dout); end
    checks++;
    if (epc_out !== 32'h5555_5554) begin errs++; $display("FAIL coll_epc_out: got %h want 55555554", epc_out); end
  endtask

  task automatic test_reset_mid();
    mtc0(5'd14, 32'h0000_3020);
    rst = 1'b0; tick(); rst = 1'b1;
    addr = 5'd12; #1;
    checks++;
    if (dout !== 32'd0) begin errs++; $display("FAIL rmid_sr: got %h want 0", dout); end
    checks++;
    if (epc_out !== 32'd0) begin errs++; $display("FAIL rmid_epc: got %h want 0", epc_out); end
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (int_req !== 1'b0) begin errs++; $display("FAIL rmid_int_req_%0d: got %0b want 0", i, int_req); end
      tick();
    end
  endtask

  task automatic test_random();
    logic [31:0] rd;
    for (int i = 0; i < 600; i++) begin
      rst    = ($urandom_range(0, 79) != 0);
      hw_int = ($urandom_range(0, 3) == 0) ? 6'($urandom) : hw_int;
      ret_pc = $urandom;
      addr   = ($urandom_range(0, 5) == 0) ? 5'($urandom) : 5'($urandom_range(12, 15));
      we     = ($urandom_range(0, 3) == 0);
      din    = $urandom;
      if (we && addr == 5'd12 && $urandom_range(0, 1) == 1) din[0] = 1'b1;
      eret   = ($urandom_range(0, 5) == 0);
      #1;
      rd = m_read(addr);
      checks++;
      if (int_req !== m_req()) begin errs++; $display("FAIL rand_int_req[%0d]: got %0b want %0b", i, int_req, m_req()); end
      checks++;
      if (epc_out !== m_epc) begin errs++; $display("FAIL rand_epc[%0d]: got %h want %h", i, epc_out, m_epc); end
      checks++;
      if (dout !== rd) begin errs++; $display("FAIL rand_read[%0d] addr %0d: got %h want %h", i, addr, dout, rd); end
      tick();
    end
    we = 1'b0; eret = 1'b0; rst = 1'b1;
  endtask

  initial begin
    checks = 0; errs = 0;
    rst = 1'b0; hw_int = '0; ret_pc = '0; addr = '0; we = 1'b0; din = '0; eret = 1'b0;
    m_sr = 0; m_epc = 0; m_hist[0] = 0; m_hist[1] = 0;
    @(negedge clk);
    test_reset();
    test_irq_entry();
    test_eret();
    test_masking();
    test_collision();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end

endmodule
